score_text_buf: RTL

SCORE_TEXT_BUF -- requirements
Module: score_text_buf

---
 rtl/score_text_buf.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/score_text_buf.sv
// rtl/score_text_buf.sv - 16x16 text-grid row showing two 5-digit player scores
module score_text_buf #(
  parameter int ROW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] score_p1,
  input  logic [15:0] score_p2,
  output logic        upd_done,
  input  logic [7:0]  char_xy,
  output logic [6:0]  char_code
);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_t;

  localparam logic [3:0] ROW_SEL = 4'(ROW);
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] sh1_q, sh2_q;
  logic [19:0] bcd1_q, bcd2_q;
  logic [6:0]  cells_q [10];
  logic        ready_q, done_q;
  logic [6:0]  char_q;

  logic [19:0] adj1_d, adj2_d;
  logic        wr_p2;
  logic [3:0]  wr_pos4;
  logic [2:0]  wr_k;
  logic [19:0] wr_bcd, wr_upper;
  logic [3:0]  wr_digit;
  logic [6:0]  wr_char;
  logic [6:0]  char_d;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift
  function automatic logic [19:0] add3(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Adjusted BCD values for the current conversion step
  always_comb begin
    adj1_d = add3(bcd1_q);
    adj2_d = add3(bcd2_q);
  end

  // Character for the digit cell addressed by the write counter, with leading-zero blanking
  always_comb begin
    wr_p2    = (cnt_q >= 4'd5);
    wr_pos4  = wr_p2 ? (cnt_q - 4'd5) : cnt_q;
    wr_k     = 3'd4 - wr_pos4[2:0];
    wr_bcd   = wr_p2 ? bcd2_q : bcd1_q;
    wr_digit = wr_bcd[{wr_k, 2'b00} +: 4];
    wr_upper = wr_bcd >> {wr_k, 2'b00};
    if ((wr_upper == 20'd0) && (wr_k != 3'd0)) wr_char = CH_SPACE;
    else                                       wr_char = {3'b011, wr_digit};
  end

  // Update FSM: accept, double-dabble conversion, digit writes, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sh1_q   <= 16'd0;
      sh2_q   <= 16'd0;
      bcd1_q  <= 20'd0;
      bcd2_q  <= 20'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < 10; i++) begin
        cells_q[i] <= ((i == 4) || (i == 9)) ? CH_ZERO : CH_SPACE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (upd_valid) begin
            sh1_q   <= score_p1;
            sh2_q   <= score_p2;
            bcd1_q  <= 20'd0;
            bcd2_q  <= 20'd0;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd1_q <= {adj1_d[18:0], sh1_q[15]};
          bcd2_q <= {adj2_d[18:0], sh2_q[15]};
          sh1_q  <= {sh1_q[14:0], 1'b0};
          sh2_q  <= {sh2_q[14:0], 1'b0};
          if (cnt_q == 4'd15) begin
            cnt_q   <= 4'd0;
            state_q <= WRITE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WRITE: begin
          cells_q[cnt_q] <= wr_char;
          if (cnt_q == 4'd9) begin
            cnt_q   <= 4'd0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Grid lookup: fixed labels, digit cells on the score row, spaces elsewhere
  always_comb begin
    char_d = CH_SPACE;
    if (char_xy[7:4] == ROW_SEL) begin
      case (char_xy[3:0])
        4'd0, 4'd8:  char_d = 7'h50;
        4'd1:        char_d = 7'h31;
        4'd9:        char_d = 7'h32;
        4'd2, 4'd10: char_d = 7'h3A;
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                     char_d = cells_q[char_xy[3:0] - 4'd3];
        default:     char_d = cells_q[char_xy[3:0] - 4'd6];
      endcase
    end
  end

  // Registered read port: one cycle from address to code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) char_q <= CH_SPACE;
    else     char_q <= char_d;
  end

  assign upd_ready = ready_q;
  assign upd_done  = done_q;
  assign char_code = char_q;

endmodule
